// File: rtl/sys_cmd_parser.sv
// Frame decoder: assembles synchronized UART RX bytes into register-file and ALU commands,
// presented on a valid/ready interface with bad-opcode, timeout and drop error pulses.
module sys_cmd_parser #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUNC_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_DATA_IN,
    input  logic                  RX_DATA_VALID,
    output logic                  CMD_VALID,
    input  logic                  CMD_READY,
    output logic [1:0]            CMD_TYPE,
    output logic [ADDR_WIDTH-1:0] CMD_ADDR,
    output logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic [DATA_WIDTH-1:0] CMD_OPA,
    output logic [DATA_WIDTH-1:0] CMD_OPB,
    output logic [FUNC_WIDTH-1:0] CMD_FUNC,
    output logic                  ERR_BAD_CMD,
    output logic                  ERR_TIMEOUT,
    output logic                  ERR_DROP
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [DATA_WIDTH-1:0] OpWrite   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OpRead    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OpAlu     = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OpAluNoOp = DATA_WIDTH'(8'hDD);

    localparam logic [1:0] TypeWrite   = 2'd0;
    localparam logic [1:0] TypeRead    = 2'd1;
    localparam logic [1:0] TypeAlu     = 2'd2;
    localparam logic [1:0] TypeAluNoOp = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StGetOpa,
        StGetOpb,
        StGetFunc,
        StIssue
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic                  valid_q;
    logic [1:0]            type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] opa_q;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [FUNC_WIDTH-1:0] func_q;
    logic                  err_bad_q;
    logic                  err_to_q;
    logic                  err_drop_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            type_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            func_q     <= '0;
            err_bad_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            err_bad_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_drop_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (RX_DATA_VALID) begin
                        if (RX_DATA_IN == OpWrite) begin
                            type_q  <= TypeWrite;
                            state_q <= StGetAddr;
                        end else if (RX_DATA_IN == OpRead) begin
                            type_q  <= TypeRead;
                            state_q <= StGetAddr;
                        end else if (RX_DATA_IN == OpAlu) begin
                            type_q  <= TypeAlu;
                            state_q <= StGetOpa;
                        end else if (RX_DATA_IN == OpAluNoOp) begin
                            type_q  <= TypeAluNoOp;
                            state_q <= StGetFunc;
                        end else begin
                            err_bad_q <= 1'b1;
                        end
                    end
                end

                StGetAddr, StGetData, StGetOpa, StGetOpb, StGetFunc: begin
                    if (RX_DATA_VALID) begin
                        cnt_q <= '0;
                        unique case (state_q)
                            StGetAddr: begin
                                addr_q <= RX_DATA_IN[ADDR_WIDTH-1:0];
                                if (type_q == TypeWrite) begin
                                    state_q <= StGetData;
                                end else begin
                                    state_q <= StIssue;
                                    valid_q <= 1'b1;
                                end
                            end
                            StGetData: begin
                                wdata_q <= RX_DATA_IN;
                                state_q <= StIssue;
                                valid_q <= 1'b1;
                            end
                            StGetOpa: begin
                                opa_q   <= RX_DATA_IN;
                                state_q <= StGetOpb;
                            end
                            StGetOpb: begin
                                opb_q   <= RX_DATA_IN;
                                state_q <= StGetFunc;
                            end
                            StGetFunc: begin
                                func_q  <= RX_DATA_IN[FUNC_WIDTH-1:0];
                                state_q <= StIssue;
                                valid_q <= 1'b1;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end else if (cnt_q == CntLast) begin
                        // Abort the partial frame; captured fields are never issued.
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        err_to_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StIssue: begin
                    cnt_q <= '0;
                    // Bytes arriving while a command is pending are lost, even on the accept edge.
                    if (RX_DATA_VALID) begin
                        err_drop_q <= 1'b1;
                    end
                    if (valid_q && CMD_READY) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign CMD_VALID   = valid_q;
    assign CMD_TYPE    = type_q;
    assign CMD_ADDR    = addr_q;
    assign CMD_WDATA   = wdata_q;
    assign CMD_OPA     = opa_q;
    assign CMD_OPB     = opb_q;
    assign CMD_FUNC    = func_q;
    assign ERR_BAD_CMD = err_bad_q;
    assign ERR_TIMEOUT = err_to_q;
    assign ERR_DROP    = err_drop_q;

endmodule

// File: tb/tb_sys_cmd_parser.sv
// Scoreboard bench for sys_cmd_parser: stimulus pushes expected commands and error pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sys_cmd_parser;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_opa;
    logic [DW-1:0] cmd_opb;
    logic [FW-1:0] cmd_func;
    logic          err_bad;
    logic          err_to;
    logic          err_drop;

    sys_cmd_parser #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FUNC_WIDTH(FW),
        .TIMEOUT   (TO)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RX_DATA_IN   (rx_data),
        .RX_DATA_VALID(rx_valid),
        .CMD_VALID    (cmd_valid),
        .CMD_READY    (cmd_ready),
        .CMD_TYPE     (cmd_type),
        .CMD_ADDR     (cmd_addr),
        .CMD_WDATA    (cmd_wdata),
        .CMD_OPA      (cmd_opa),
        .CMD_OPB      (cmd_opb),
        .CMD_FUNC     (cmd_func),
        .ERR_BAD_CMD  (err_bad),
        .ERR_TIMEOUT  (err_to),
        .ERR_DROP     (err_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [FW-1:0] func;
        int            rise;
    } cmd_t;

    typedef struct {
        int kind;  // 0 bad opcode, 1 timeout, 2 drop
        int cyc;
    } err_t;

    cmd_t cq[$];
    err_t eq[$];

    int n_pass = 0;
    int n_chk  = 0;

    // Reference copy of the command fields as the consumer should see them.
    logic [1:0]    m_type  = '0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_opa   = '0;
    logic [DW-1:0] m_opb   = '0;
    logic [FW-1:0] m_func  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_cmd(input int rise);
        cmd_t c;
        c.typ   = m_type;
        c.addr  = m_addr;
        c.wdata = m_wdata;
        c.opa   = m_opa;
        c.opb   = m_opb;
        c.func  = m_func;
        c.rise  = rise;
        cq.push_back(c);
    endtask

    task automatic push_err(input int kind, input int at);
        err_t e;
        e.kind = kind;
        e.cyc  = at;
        eq.push_back(e);
    endtask

    task automatic model_reset();
        m_type  = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_opa   = '0;
        m_opb   = '0;
        m_func  = '0;
    endtask

    task automatic send(input logic [DW-1:0] b, output int c);
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_err(input int kind);
        err_t e;
        if (eq.size() == 0) begin
            chk("unexpected_err_pulse", 64'(kind), 64'(-1));
        end else begin
            e = eq.pop_front();
            chk("err_kind", 64'(kind), 64'(e.kind));
            chk("err_cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    logic prev_valid = 1'b0;
    int   rise_cyc = 0;

    always @(negedge clk) begin
        cmd_t c;
        if (cmd_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = cmd_valid;
        if (cmd_valid && cmd_ready) begin
            if (cq.size() == 0) begin
                chk("unexpected_cmd", 64'(cmd_type), 64'(-1));
            end else begin
                c = cq.pop_front();
                chk("cmd_type", 64'(cmd_type), 64'(c.typ));
                chk("cmd_addr", 64'(cmd_addr), 64'(c.addr));
                chk("cmd_wdata", 64'(cmd_wdata), 64'(c.wdata));
                chk("cmd_opa", 64'(cmd_opa), 64'(c.opa));
                chk("cmd_opb", 64'(cmd_opb), 64'(c.opb));
                chk("cmd_func", 64'(cmd_func), 64'(c.func));
                chk("cmd_rise_cycle", 64'(rise_cyc), 64'(c.rise));
            end
        end
        if (err_bad) pop_err(0);
        if (err_to) pop_err(1);
        if (err_drop) pop_err(2);
    end

    function automatic logic [63:0] all_outputs();
        return 64'({cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_func,
                    err_bad, err_to, err_drop});
    endfunction

    initial begin
        int c;
        int d;

        idle(3);
        chk("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Write with consumer ready: one-cycle valid, one cycle after the data byte.
        cmd_ready = 1'b1;
        send(8'hAA, c);
        send(8'h05, c);
        send(8'h3C, c);
        m_type = 2'd0; m_addr = 4'h5; m_wdata = 8'h3C;
        push_cmd(c + 1);
        idle(3);

        // ALU frame held by the consumer; a stray byte is dropped without touching fields.
        cmd_ready = 1'b0;
        send(8'hCC, c);
        send(8'h12, c);
        send(8'h34, c);
        send(8'hF1, c);
        m_type = 2'd2; m_opa = 8'h12; m_opb = 8'h34; m_func = 4'h1;
        push_cmd(c + 1);
        idle(3);
        send(8'hBB, d);
        push_err(2, d + 1);
        idle(7);
        chk("alu_held_valid", 64'(cmd_valid), 64'd1);
        cmd_ready = 1'b1;
        idle(1);

        // Bad opcode immediately after acceptance, then a back-to-back read.
        send(8'h55, d);
        push_err(0, d + 1);
        send(8'hBB, c);
        send(8'h0A, c);
        m_type = 2'd1; m_addr = 4'hA;
        push_cmd(c + 1);
        idle(3);

        // Opcode then silence: timeout TO+1 cycles after the opcode cycle.
        send(8'hAA, d);
        m_type = 2'd0;
        push_err(1, d + TO + 1);
        idle(TO + 4);

        // Address on the last allowed idle cycle is accepted.
        send(8'hAA, d);
        idle(TO - 1);
        send(8'h17, c);
        chk("late_byte_cycle", 64'(c), 64'(d + TO));
        send(8'h99, c);
        m_addr = 4'h7; m_wdata = 8'h99;
        push_cmd(c + 1);
        idle(TO + 3);

        // No-operand ALU: operands keep the previous ALU command's values.
        send(8'hDD, c);
        send(8'h07, c);
        m_type = 2'd3; m_func = 4'h7;
        push_cmd(c + 1);
        idle(3);

        // Reset in GET_OPB clears everything asynchronously.
        send(8'hCC, c);
        send(8'h11, c);
        rst_n = 1'b0;
        #1;
        chk("reset_in_get_opb", all_outputs(), 64'd0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Reset while a command is pending.
        cmd_ready = 1'b0;
        send(8'hCC, c);
        send(8'hAB, c);
        send(8'hCD, c);
        send(8'hE2, c);
        idle(2);
        chk("issue_pending_valid", 64'(cmd_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_in_issue", all_outputs(), 64'd0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Fresh read after reset; unused fields must read as cleared.
        cmd_ready = 1'b1;
        send(8'hBB, c);
        send(8'h03, c);
        m_type = 2'd1; m_addr = 4'h3;
        push_cmd(c + 1);
        idle(3);

        // Byte arriving on the accepting edge is dropped, not taken as an opcode.
        cmd_ready = 1'b0;
        send(8'hBB, c);
        send(8'h02, c);
        m_type = 2'd1; m_addr = 4'h2;
        push_cmd(c + 1);
        idle(2);
        cmd_ready = 1'b1;
        send(8'hAA, d);
        push_err(2, d + 1);
        idle(TO + 6);

        chk("cmd_queue_drained", 64'(cq.size()), 64'd0);
        chk("err_queue_drained", 64'(eq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
